fifo_push_arbiter: RTL and testbench
====================================

// Module: fifo_push_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one FWFT FIFO write port among N_REQ producers.
//  Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a
//  time for a bounded burst and drives the FIFO push/write_data/fifo_full interface.
//  Sits between producer blocks and the FIFO write side; the read side is untouched.
// PARAMETERS
//  WIDTH      8  data word width; must match the FIFO WIDTH
//  N_REQ      4  number of requesters, >=2
//  MAX_BURST  4  max words per grant, >=1
// PORTS
//  clk         in   1              clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  req_valid   in   N_REQ          producer i has a word
//  req_data    in   N_REQ*WIDTH    word of producer i at bits [i*WIDTH +: WIDTH]
//  req_ready   out  N_REQ          word of producer i accepted this cycle when valid&ready
//  fifo_full   in   1              FIFO full flag
//  fifo_push   out  1              FIFO write strobe
//  fifo_wdata  out  WIDTH          FIFO write data
//  grant_id    out  $clog2(N_REQ)  currently/last granted requester
//  busy        out  1              state==BURST
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, grant_id=0, last_grant=N_REQ-1, so requester 0 wins first; beat_cnt=0.
//   - fifo_push=0, req_ready=0, busy=0.
//  IDLE:
//   - req_ready=0, fifo_push=0; no transfer ever happens in IDLE.
//   - If any req_valid: pick the first valid index scanning last_grant+1, +2, ... modulo N_REQ.
//   - Register grant_id=pick, last_grant=pick, beat_cnt=0; go to BURST.
//   - Arbitration latency is 1 cycle, plus a 1-cycle bubble between grants (accepted by design).
//  BURST, g=grant_id:
//   - req_ready[g]=!fifo_full; all other req_ready bits are 0.
//   - fifo_push=req_valid[g]&!fifo_full; fifo_wdata=req_data[g] (combinational; else data don't-care, push 0).
//   - Transfer beat = fifo_push. On a beat, beat_cnt++.
//   - Exit to IDLE when a beat occurs with beat_cnt==MAX_BURST-1, or when req_valid[g]==0 (no beat that cycle).
//   - fifo_full with req_valid[g]=1: hold grant, no push, beat_cnt unchanged; stall is unbounded.
//  Handshake: a producer must hold req_valid and req_data stable until accepted. The arbiter never pushes while fifo_full=1.
//  Width rules:
//   - beat_cnt is $clog2(MAX_BURST+1) bits wide.
//   - Pointer wrap is explicit: N_REQ-1 -> 0, correct for non-power-of-2 N_REQ.
//  Simultaneous events: a new requester asserting valid mid-burst waits; it is considered at the next IDLE.
//  Fairness: a requester that stays valid is granted within N_REQ-1 other grants.
//  Reset mid-burst: push drops immediately; the partial burst is not replayed.
// STRUCTURE
//  Package fifo_arb_pkg:
//   - typedef enum logic {IDLE, BURST} arb_state_t.
//   - Function next_rr(last, vec, n) returns the first set index after last.
//  Sub-module rr_picker: combinational; inputs vec[N_REQ] and last; outputs pick and any.
//  Top: state/grant/beat registers plus output mux.
// TESTING
//  Scenario 1, single requester:
//   - Stimulus: req_valid=4'b0001 streaming 0xA0..0xA5, MAX_BURST=4, fifo_full=0.
//   - Response: pushes A0..A3, then a 1-cycle IDLE bubble, then A4,A5, then release.
//  Scenario 2, all requesters valid:
//   - Stimulus: req_valid=4'b1111 continuously after reset.
//   - Response: grant order 0,1,2,3,0; 4 beats each.
//  Scenario 3, backpressure:
//   - Stimulus: fifo_full=1 for 3 cycles during beat 2 of requester 1's burst.
//   - Response: push=0 and ready=0 during stall; beat 3 resumes; the grant stays 1.
//  Scenario 4, early release:
//   - Stimulus: requester 2 drops valid after 2 beats.
//   - Response: IDLE next cycle; the next grant scans from 3.
//  Scenario 5, reset mid-burst:
//   - Stimulus: rst_n low during a burst.
//   - Response: push, ready and busy are 0 within the same cycle; the next grant goes to requester 0 if it is valid.
//  Scenario 6, N_REQ=3:
//   - Stimulus: req_valid=3'b101.
//   - Response: grants 0,2,0,2 with correct wrap.
//  All scenarios: the scoreboard checks FIFO contents order against accepted beats.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin scan helper for the FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int RR_MAX  = 32;
    localparam int RR_IDXW = $clog2(RR_MAX);

    // First set index after 'last', wrapping n-1 -> 0; returns 'last' when vec is empty.
    function automatic int next_rr(input int last, input logic [RR_MAX-1:0] vec, input int n);
        int   idx;
        int   pick;
        logic found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (!found && k <= n && vec[idx[RR_IDXW-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Round-robin pick of the next valid requester after the last grant.
// Latency: combinational.
// Backpressure: none; pure function of vec and last.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] vec,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   pick,
    output logic             any
);

    logic [RR_MAX-1:0] vec_ext;

    // N_REQ is limited to RR_MAX requesters by the helper's vector width.
    always_comb begin
        vec_ext = RR_MAX'(vec);
        pick    = IDW'(next_rr(int'(last), vec_ext, N_REQ));
        any     = |vec;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Latency: 1 cycle from valid to grant, pushes are combinational within a burst, 1-cycle bubble between grants.
// Backpressure: fifo_full stalls the granted producer (ready low, no push) for as long as it lasts.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int N_REQ     = 4,
    parameter  int MAX_BURST = 4,
    localparam int IDW       = $clog2(N_REQ),
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_push,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic [IDW-1:0]         grant_id,
    output logic                   busy
);

    arb_state_t     state, state_nxt;
    logic [IDW-1:0] last_grant, last_nxt, grant_nxt, pick;
    logic [BCW-1:0] beat_cnt, beat_nxt;
    logic           any;

    rr_picker #(.N_REQ(N_REQ)) u_pick (
        .vec  (req_valid),
        .last (last_grant),
        .pick (pick),
        .any  (any)
    );

    // last_grant resets to the top index so requester 0 wins the first scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(N_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        last_nxt   = last_grant;
        beat_nxt   = beat_cnt;
        req_ready  = '0;
        fifo_push  = 1'b0;
        busy       = 1'b0;
        fifo_wdata = req_data[int'(grant_id)*WIDTH +: WIDTH];
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = BURST;
                    grant_nxt = pick;
                    last_nxt  = pick;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                busy                = 1'b1;
                req_ready[grant_id] = !fifo_full;
                fifo_push           = req_valid[grant_id] & !fifo_full;
                if (fifo_push) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == BCW'(MAX_BURST - 1)) state_nxt = IDLE;
                end else if (!req_valid[grant_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: producer queues, a transaction-level reference model and a FIFO scoreboard.
module tb_fifo_push_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n, rst3_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_data;
    logic           fifo_full, fifo_push, busy;
    logic [W-1:0]   fifo_wdata;
    logic [1:0]     grant_id;

    logic [2:0]     rv3, ready3;
    logic [23:0]    rd3;
    logic           full3, push3, busy3;
    logic [7:0]     wdata3;
    logic [1:0]     gid3;

    int             ncmp = 0;
    int             nerr = 0;
    bit [7:0]       src_q [N][$];
    bit [7:0]       exp_fifo [$];
    bit [7:0]       got_fifo [$];
    int             dut_glog [$];
    int             glog3 [$];
    bit             m_busy;
    int             m_grant, m_last, m_beats;
    logic [N-1:0]   acc_last;
    int             full_pct, en_pct;
    bit             pb, pb3;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_push  (fifo_push),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    fifo_push_arbiter #(.WIDTH(8), .N_REQ(3), .MAX_BURST(4)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst3_n),
        .req_valid  (rv3),
        .req_data   (rd3),
        .req_ready  (ready3),
        .fifo_full  (full3),
        .fifo_push  (push3),
        .fifo_wdata (wdata3),
        .grant_id   (gid3),
        .busy       (busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // A producer keeps an offered word up until the cycle it is accepted.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !acc_last[i]))
                req_valid[i] = (src_q[i].size() > 0) && ($urandom_range(99) < en_pct);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : 8'($urandom);
        end
        fifo_full = ($urandom_range(99) < full_pct);
    endtask

    task automatic step_check();
        logic [N-1:0] exp_ready;
        drive();
        @(negedge clk);
        exp_ready = (m_busy && !fifo_full) ? (N'(1) << m_grant) : '0;
        check("busy", busy, m_busy);
        check("grant_id", grant_id, m_grant);
        check("push", fifo_push, m_busy && req_valid[m_grant] && !fifo_full);
        check("ready", req_ready, exp_ready);
        if (m_busy && req_valid[m_grant] && fifo_push === 1'b1)
            check("wdata", fifo_wdata, src_q[m_grant][0]);
        if (busy === 1'b1 && !pb) dut_glog.push_back(int'(grant_id));
        pb = (busy === 1'b1);
        if (busy3 === 1'b1 && !pb3) glog3.push_back(int'(gid3));
        pb3 = (busy3 === 1'b1);
        check("n3_push", push3, busy3);
        check("n3_ready", ready3, (busy3 === 1'b1) ? (3'b001 << gid3) : 3'b000);
        if (push3 === 1'b1) check("n3_wdata", wdata3, 8'hC0 + gid3);
    endtask

    task automatic step_commit();
        logic [N-1:0] acc;
        acc = '0;
        if (!m_busy) begin
            if (req_valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_last + k) % N]) begin
                        m_grant = (m_last + k) % N;
                        break;
                    end
                end
                m_last  = m_grant;
                m_beats = 0;
                m_busy  = 1'b1;
            end
        end else if (req_valid[m_grant] && !fifo_full) begin
            exp_fifo.push_back(src_q[m_grant].pop_front());
            acc[m_grant] = 1'b1;
            m_beats++;
            if (m_beats == MB) m_busy = 1'b0;
        end else if (!req_valid[m_grant]) begin
            m_busy = 1'b0;
        end
        if (fifo_push === 1'b1) got_fifo.push_back(fifo_wdata);
        acc_last = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        step_check();
        step_commit();
    endtask

    task automatic drain(input int max, input string tag);
        int c = 0;
        while (!(all_empty() && !m_busy) && c < max) begin
            step();
            c++;
        end
        check(tag, all_empty() && !m_busy, 1);
    endtask

    // Any pending accept from the last check is dropped: the reset edge cancels it.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_push", fifo_push, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_busy   = 1'b0;
        m_grant  = 0;
        m_last   = N - 1;
        m_beats  = 0;
        acc_last = '0;
    endtask

    initial begin
        int g0;
        int s4_exp [3];
        bit hit;
        int c;
        s4_exp    = '{2, 0, 1};
        rst_n     = 1'b1;
        rst3_n    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        rv3       = 3'b101;
        rd3       = {8'hC2, 8'hC1, 8'hC0};
        full3     = 1'b0;
        full_pct  = 0;
        en_pct    = 100;
        acc_last  = '0;
        pb        = 1'b0;
        pb3       = 1'b0;
        #1;
        rst3_n = 1'b0;
        do_reset();
        rst3_n = 1'b1;

        // Single requester streaming A0..A5: bursts of 4 then 2 with a bubble.
        for (int k = 0; k < 6; k++) src_q[0].push_back(8'(8'hA0 + k));
        drain(40, "s1_drain");
        check("s1_count", got_fifo.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < got_fifo.size()) check("s1_word", got_fifo[k], 8'hA0 + k);

        // All requesters valid after reset: grants rotate from 0.
        do_reset();
        g0 = dut_glog.size();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(8'($urandom));
        drain(200, "s2_drain");
        check("s2_ngrants", dut_glog.size() - g0, 8);
        for (int k = 0; k < 5; k++)
            if (g0 + k < dut_glog.size()) check("s2_order", dut_glog[g0 + k], k % N);

        // Backpressure on requester 1 after its first beat.
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h50 + k));
        step();
        step_check();
        check("s3_beat1", fifo_push, 1);
        step_commit();
        full_pct = 100;
        repeat (3) begin
            step_check();
            check("s3_stall_push", fifo_push, 0);
            check("s3_stall_ready", req_ready, 0);
            check("s3_stall_grant", grant_id, 1);
            step_commit();
        end
        full_pct = 0;
        step_check();
        check("s3_resume", fifo_push, 1);
        check("s3_resume_grant", grant_id, 1);
        step_commit();
        drain(40, "s3_drain");

        // Requester 2 releases after two beats; the next scan starts at 3.
        g0 = dut_glog.size();
        for (int k = 0; k < 2; k++) src_q[2].push_back(8'(8'h20 + k));
        for (int k = 0; k < 4; k++) src_q[0].push_back(8'(8'h00 + k));
        for (int k = 0; k < 2; k++) src_q[1].push_back(8'(8'h10 + k));
        drain(60, "s4_drain");
        check("s4_ngrants", dut_glog.size() - g0, 3);
        for (int k = 0; k < 3; k++)
            if (g0 + k < dut_glog.size()) check("s4_order", dut_glog[g0 + k], s4_exp[k]);

        // Random traffic and backpressure, then a reset in the middle of a burst.
        en_pct   = 50;
        full_pct = 25;
        for (int i = 0; i < N; i++) begin
            int n = $urandom_range(10);
            for (int k = 0; k < n; k++) src_q[i].push_back(8'($urandom));
        end
        repeat (150) step();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) src_q[i].push_back(8'($urandom));
        hit = 1'b0;
        c   = 0;
        while (!hit && c < 60) begin
            step_check();
            if (busy === 1'b1 && fifo_push === 1'b1) hit = 1'b1;
            else step_commit();
            c++;
        end
        check("s5_burst_found", hit, 1);
        for (int k = 0; k < 2; k++) src_q[0].push_back(8'($urandom));
        do_reset();
        en_pct   = 100;
        full_pct = 0;
        step_check();
        check("s5_idle_after_rst", busy, 0);
        step_commit();
        step_check();
        check("s5_regrant", grant_id, 0);
        check("s5_regrant_busy", busy, 1);
        step_commit();
        drain(400, "s5_drain");

        check("sb_count", got_fifo.size(), exp_fifo.size());
        for (int k = 0; k < exp_fifo.size(); k++)
            if (k < got_fifo.size()) check("sb_word", got_fifo[k], exp_fifo[k]);

        check("n3_ngrants", glog3.size() >= 4, 1);
        for (int k = 0; k < glog3.size(); k++) check("n3_order", glog3[k], (k % 2) * 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
